fft_butterfly_1: RTL and testbench

//  Radix-2 DIT butterfly for the fft_1 datapath: X = A + W*B, Y = A - W*B.

---
 rtl/fft_butterfly_1.sv | 185 ++++++++++++++++++
 tb/tb_fft_butterfly_1.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_butterfly_1.sv
// Radix-2 DIT butterfly X = A + W*B, Y = A - W*B around an external fixed-latency
// complex multiplier, with optional /2 scaling, saturation and a sticky overflow flag.
module fft_butterfly_1 #(
  parameter int unsigned DW           = 12,
  parameter int unsigned MULT_LATENCY = 8,
  parameter int unsigned SCALE        = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [DW-1:0] i_a_re,
  input  logic [DW-1:0] i_a_im,
  input  logic [DW-1:0] i_b_re,
  input  logic [DW-1:0] i_b_im,
  input  logic [DW-1:0] i_tw_re,
  input  logic [DW-1:0] i_tw_im,
  output logic [DW-1:0] o_mul_a,
  output logic [DW-1:0] o_mul_b,
  output logic [DW-1:0] o_mul_c,
  output logic [DW-1:0] o_mul_d,
  output logic          o_mul_en,
  input  logic [23:0]   i_mul_real,
  input  logic [23:0]   i_mul_img,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [DW-1:0] o_x_re,
  output logic [DW-1:0] o_x_im,
  output logic [DW-1:0] o_y_re,
  output logic [DW-1:0] o_y_im,
  output logic          o_ovf,
  input  logic          i_ovf_clr
);

  localparam int unsigned PW = 17;
  localparam int unsigned SW = PW + 1;
  localparam int unsigned CW = (MULT_LATENCY > 1) ? $clog2(MULT_LATENCY) : 1;
  localparam logic [CW-1:0]        CNT_LAST = CW'(MULT_LATENCY - 1);
  localparam logic signed [SW-1:0] SMAX     = SW'((1 << (DW - 1)) - 1);
  localparam logic signed [SW-1:0] SMIN     = ~SMAX;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_SUM, S_OUT} state_t;

  state_t               r_state, w_state_nxt;
  logic [CW-1:0]        r_cnt, w_cnt_nxt;
  logic                 w_accept, w_capture, w_compute;
  logic [DW-1:0]        r_a_re, r_a_im, r_b_re, r_b_im, r_tw_re, r_tw_im;
  logic [PW-1:0]        r_wb_re, r_wb_im;
  logic                 r_in_ready, r_mul_en, r_out_valid, r_ovf;
  logic [DW-1:0]        r_x_re, r_x_im, r_y_re, r_y_im;
  logic signed [SW-1:0] w_a_re, w_a_im, w_wb_re, w_wb_im;
  logic [DW:0]          w_sx_re, w_sx_im, w_sy_re, w_sy_im;
  logic                 w_clip;
  logic                 w_unused;

  function automatic logic signed [SW-1:0] scale_f(input logic signed [SW-1:0] v);
    return (SCALE != 0) ? (v >>> 1) : v;
  endfunction

  // MSB of the result flags that the value was clipped
  function automatic logic [DW:0] sat_f(input logic signed [SW-1:0] v);
    logic [DW:0] r;
    if (v > SMAX)      r = {1'b1, SMAX[DW-1:0]};
    else if (v < SMIN) r = {1'b1, SMIN[DW-1:0]};
    else               r = {1'b0, v[DW-1:0]};
    return r;
  endfunction

  assign w_a_re  = SW'($signed(r_a_re));
  assign w_a_im  = SW'($signed(r_a_im));
  assign w_wb_re = SW'($signed(r_wb_re));
  assign w_wb_im = SW'($signed(r_wb_im));

  assign w_sx_re = sat_f(scale_f(w_a_re + w_wb_re));
  assign w_sx_im = sat_f(scale_f(w_a_im + w_wb_im));
  assign w_sy_re = sat_f(scale_f(w_a_re - w_wb_re));
  assign w_sy_im = sat_f(scale_f(w_a_im - w_wb_im));
  assign w_clip  = w_sx_re[DW] | w_sx_im[DW] | w_sy_re[DW] | w_sy_im[DW];

  // Multiplier guard bits above the 17-bit product carry no information
  assign w_unused = ^{i_mul_real[23:PW], i_mul_img[23:PW]};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_compute   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_in_ready && i_in_valid) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_MUL;
        end
      end
      S_MUL: begin
        if (r_cnt == CNT_LAST) begin
          w_capture   = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_SUM;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_SUM: begin
        w_compute   = 1'b1;
        w_state_nxt = S_OUT;
      end
      S_OUT: begin
        if (i_out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, counter and handshake/enable flags registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_mul_en    <= 1'b0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_mul_en    <= (w_state_nxt == S_MUL);
      r_out_valid <= (w_state_nxt == S_OUT);
      r_ovf       <= (r_ovf & ~i_ovf_clr) | (w_compute & w_clip);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_re  <= '0;
      r_a_im  <= '0;
      r_b_re  <= '0;
      r_b_im  <= '0;
      r_tw_re <= '0;
      r_tw_im <= '0;
      r_wb_re <= '0;
      r_wb_im <= '0;
      r_x_re  <= '0;
      r_x_im  <= '0;
      r_y_re  <= '0;
      r_y_im  <= '0;
    end else begin
      if (w_accept) begin
        r_a_re  <= i_a_re;
        r_a_im  <= i_a_im;
        r_b_re  <= i_b_re;
        r_b_im  <= i_b_im;
        r_tw_re <= i_tw_re;
        r_tw_im <= i_tw_im;
      end
      if (w_capture) begin
        r_wb_re <= i_mul_real[PW-1:0];
        r_wb_im <= i_mul_img[PW-1:0];
      end
      if (w_compute) begin
        r_x_re <= w_sx_re[DW-1:0];
        r_x_im <= w_sx_im[DW-1:0];
        r_y_re <= w_sy_re[DW-1:0];
        r_y_im <= w_sy_im[DW-1:0];
      end
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_mul_a     = r_b_re;
  assign o_mul_b     = r_b_im;
  assign o_mul_c     = r_tw_re;
  assign o_mul_d     = r_tw_im;
  assign o_mul_en    = r_mul_en;
  assign o_out_valid = r_out_valid;
  assign o_x_re      = r_x_re;
  assign o_x_im      = r_x_im;
  assign o_y_re      = r_y_re;
  assign o_y_im      = r_y_im;
  assign o_ovf       = r_ovf;

endmodule

// File: tb/tb_fft_butterfly_1.sv
// Bench for fft_butterfly_1: an unscaled and a scaled instance share stimulus and are
// checked every cycle against an arithmetic butterfly model and a latency-accurate multiplier.
module tb_fft_butterfly_1;

  localparam int unsigned DW = 12;
  localparam int unsigned L  = 8;
  localparam int MAXV = 2047;
  localparam int MINV = -2048;

  typedef struct packed {
    int   xr;
    int   xi;
    int   yr;
    int   yi;
    logic clip;
  } res_t;

  logic clk = 1'b0;
  logic rst_n, in_valid, out_ready, ovf_clr;
  logic [DW-1:0] a_re, a_im, b_re, b_im, tw_re, tw_im;
  logic          in_ready[2], mul_en[2], out_valid[2], ovf[2];
  logic [DW-1:0] mul_a[2], mul_b[2], mul_c[2], mul_d[2];
  logic [DW-1:0] x_re[2], x_im[2], y_re[2], y_im[2];
  logic [23:0]   mul_real[2], mul_img[2];
  int            en_cnt[2];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fft_butterfly_1 #(.DW(DW), .MULT_LATENCY(L), .SCALE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready[0]),
    .i_a_re(a_re), .i_a_im(a_im), .i_b_re(b_re), .i_b_im(b_im),
    .i_tw_re(tw_re), .i_tw_im(tw_im),
    .o_mul_a(mul_a[0]), .o_mul_b(mul_b[0]), .o_mul_c(mul_c[0]), .o_mul_d(mul_d[0]),
    .o_mul_en(mul_en[0]), .i_mul_real(mul_real[0]), .i_mul_img(mul_img[0]),
    .o_out_valid(out_valid[0]), .i_out_ready(out_ready),
    .o_x_re(x_re[0]), .o_x_im(x_im[0]), .o_y_re(y_re[0]), .o_y_im(y_im[0]),
    .o_ovf(ovf[0]), .i_ovf_clr(ovf_clr)
  );

  fft_butterfly_1 #(.DW(DW), .MULT_LATENCY(L), .SCALE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready[1]),
    .i_a_re(a_re), .i_a_im(a_im), .i_b_re(b_re), .i_b_im(b_im),
    .i_tw_re(tw_re), .i_tw_im(tw_im),
    .o_mul_a(mul_a[1]), .o_mul_b(mul_b[1]), .o_mul_c(mul_c[1]), .o_mul_d(mul_d[1]),
    .o_mul_en(mul_en[1]), .i_mul_real(mul_real[1]), .i_mul_img(mul_img[1]),
    .o_out_valid(out_valid[1]), .i_out_ready(out_ready),
    .o_x_re(x_re[1]), .o_x_im(x_im[1]), .o_y_re(y_re[1]), .o_y_im(y_im[1]),
    .o_ovf(ovf[1]), .i_ovf_clr(ovf_clr)
  );

  function automatic int mre(input int br, input int bi, input int wr, input int wi);
    return (br * wr - bi * wi) >>> 7;
  endfunction

  function automatic int mim(input int br, input int bi, input int wr, input int wi);
    return (br * wi + bi * wr) >>> 7;
  endfunction

  function automatic int sat(input int v);
    return (v > MAXV) ? MAXV : ((v < MINV) ? MINV : v);
  endfunction

  function automatic res_t model(input int ar, input int ai, input int br, input int bi,
                                 input int wr, input int wi, input bit scale);
    int   raw[4];
    int   wbr, wbi;
    res_t r;
    wbr = mre(br, bi, wr, wi);
    wbi = mim(br, bi, wr, wi);
    raw[0] = ar + wbr;
    raw[1] = ai + wbi;
    raw[2] = ar - wbr;
    raw[3] = ai - wbi;
    r.clip = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (scale) raw[i] = raw[i] >>> 1;
      if (sat(raw[i]) != raw[i]) r.clip = 1'b1;
      raw[i] = sat(raw[i]);
    end
    r.xr = raw[0];
    r.xi = raw[1];
    r.yr = raw[2];
    r.yi = raw[3];
    return r;
  endfunction

  // Multiplier stand-in: result only valid MULT_LATENCY cycles after mul_en rises
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++)
      en_cnt[k] <= (!rst_n) ? 0 : (mul_en[k] ? en_cnt[k] + 1 : 0);
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      mul_real[k] = 24'h2AAAAA;
      mul_img[k]  = 24'h155555;
      if (mul_en[k] && en_cnt[k] >= int'(L) - 1) begin
        mul_real[k] = {7'h55, 17'(mre($signed(mul_a[k]), $signed(mul_b[k]),
                                       $signed(mul_c[k]), $signed(mul_d[k])))};
        mul_img[k]  = {7'h55, 17'(mim($signed(mul_a[k]), $signed(mul_b[k]),
                                       $signed(mul_c[k]), $signed(mul_d[k])))};
      end
    end
  end

  task automatic chk(input string nm, input int k, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0d expected %0d at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Scoreboard state for the single outstanding butterfly
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   busy = 1'b0;
  bit   fresh = 1'b0;
  bit   clr_prev = 1'b0;
  bit   seen[2];
  logic ovf_exp[2];
  res_t exp_r[2];
  res_t hold[2];
  int   op_br, op_bi, op_wr, op_wi;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        chk("rst_in_ready", k, in_ready[k], 0);
        chk("rst_mul_en", k, mul_en[k], 0);
        chk("rst_out_valid", k, out_valid[k], 0);
        chk("rst_ovf", k, ovf[k], 0);
        chk("rst_xy", k, int'({x_re[k], x_im[k], y_re[k], y_im[k]} != '0), 0);
        seen[k]    = 1'b0;
        ovf_exp[k] = 1'b0;
        hold[k]    = '0;
      end
      busy     = 1'b0;
      fresh    = 1'b1;
      clr_prev = 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (clr_prev) ovf_exp[k] = 1'b0;
        if (out_valid[k]) begin
          if (!busy) chk("spurious_out_valid", k, 1, 0);
          else begin
            if (!seen[k]) begin
              chk("latency", k, cyc - acc_cyc, int'(L) + 2);
              ovf_exp[k] = ovf_exp[k] | exp_r[k].clip;
              seen[k]    = 1'b1;
            end
            chk("x_re", k, $signed(x_re[k]), exp_r[k].xr);
            chk("x_im", k, $signed(x_im[k]), exp_r[k].xi);
            chk("y_re", k, $signed(y_re[k]), exp_r[k].yr);
            chk("y_im", k, $signed(y_im[k]), exp_r[k].yi);
          end
        end else begin
          if (busy && seen[k]) chk("out_valid_dropped", k, 0, 1);
          chk("x_re_hold", k, $signed(x_re[k]), hold[k].xr);
          chk("x_im_hold", k, $signed(x_im[k]), hold[k].xi);
          chk("y_re_hold", k, $signed(y_re[k]), hold[k].yr);
          chk("y_im_hold", k, $signed(y_im[k]), hold[k].yi);
        end
        chk("ovf", k, ovf[k], ovf_exp[k]);
        chk("in_ready", k, in_ready[k], (fresh || busy) ? 0 : 1);
        chk("mul_en", k, mul_en[k],
            (busy && (cyc - acc_cyc) >= 1 && (cyc - acc_cyc) <= int'(L)) ? 1 : 0);
        if (mul_en[k]) begin
          chk("mul_a", k, $signed(mul_a[k]), op_br);
          chk("mul_b", k, $signed(mul_b[k]), op_bi);
          chk("mul_c", k, $signed(mul_c[k]), op_wr);
          chk("mul_d", k, $signed(mul_d[k]), op_wi);
        end
      end
      fresh    = 1'b0;
      clr_prev = ovf_clr;
      if (busy && out_valid[0] && out_ready) begin
        busy = 1'b0;
        for (int k = 0; k < 2; k++) begin
          hold[k] = exp_r[k];
          seen[k] = 1'b0;
        end
      end else if (!busy && in_valid && in_ready[0]) begin
        busy     = 1'b1;
        acc_cyc  = cyc;
        op_br    = $signed(b_re);
        op_bi    = $signed(b_im);
        op_wr    = $signed(tw_re);
        op_wi    = $signed(tw_im);
        exp_r[0] = model($signed(a_re), $signed(a_im), op_br, op_bi, op_wr, op_wi, 1'b0);
        exp_r[1] = model($signed(a_re), $signed(a_im), op_br, op_bi, op_wr, op_wi, 1'b1);
      end
    end
  end

  task automatic pin(input string nm, input int ar, input int ai, input int br, input int bi,
                     input int wr, input int wi, input bit scale,
                     input int xr, input int xi, input int yr, input int yi, input bit clip);
    res_t r;
    r = model(ar, ai, br, bi, wr, wi, scale);
    chk({nm, "_xr"}, int'(scale), r.xr, xr);
    chk({nm, "_xi"}, int'(scale), r.xi, xi);
    chk({nm, "_yr"}, int'(scale), r.yr, yr);
    chk({nm, "_yi"}, int'(scale), r.yi, yi);
    chk({nm, "_clip"}, int'(scale), r.clip, clip);
  endtask

  task automatic send(input int ar, input int ai, input int br, input int bi,
                      input int wr, input int wi);
    bit ok = 1'b0;
    a_re  = DW'(ar);
    a_im  = DW'(ai);
    b_re  = DW'(br);
    b_im  = DW'(bi);
    tw_re = DW'(wr);
    tw_im = DW'(wi);
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready[0]) ok = 1'b1;
    end
    if (!ok) chk("accept_timeout", 0, 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out();
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (out_valid[0] && out_ready) ok = 1'b1;
    end
    if (!ok) chk("output_timeout", 0, 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int ar, input int ai, input int br, input int bi,
                     input int wr, input int wi);
    send(ar, ai, br, bi, wr, wi);
    wait_out();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0; tw_re = '0; tw_im = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Hand-computed values pin the arithmetic model
    pin("T1", 100, 0, 64, 0, 128, 0, 1'b0, 164, 0, 36, 0, 1'b0);
    pin("T1", 100, 0, 64, 0, 128, 0, 1'b1, 82, 0, 18, 0, 1'b0);
    pin("T2", 0, 0, 10, 20, 0, -128, 1'b0, 20, -10, -20, 10, 1'b0);
    pin("T2", 0, 0, 10, 20, 0, -128, 1'b1, 10, -5, -10, 5, 1'b0);
    pin("T3", 2047, -2048, 100, -100, 128, 0, 1'b0, 2047, -2048, 1947, -1948, 1'b1);
    pin("T4", 2047, -2048, 100, -100, 128, 0, 1'b1, 1073, -1074, 973, -974, 1'b0);

    run(100, 0, 64, 0, 128, 0);
    run(0, 0, 10, 20, 0, -128);
    run(2047, -2048, 100, -100, 128, 0);
    @(negedge clk);
    chk("T3_ovf_set", 0, ovf[0], 1);
    chk("T4_ovf_clear", 1, ovf[1], 0);
    @(posedge clk);
    #1 ovf_clr = 1'b1;
    @(posedge clk);
    #1 ovf_clr = 1'b0;
    @(negedge clk);
    chk("T3_ovf_cleared", 0, ovf[0], 0);

    // Clear held across the saturating result: set must win on that edge
    ovf_clr = 1'b1;
    run(-2048, 2047, -2048, -2048, -128, -128);
    ovf_clr = 1'b0;

    // Stall in OUT with ignored input pulses
    out_ready = 1'b0;
    send(100, 0, 64, 0, 128, 0);
    repeat (20) begin
      @(posedge clk);
      #1;
      in_valid = 1'($urandom_range(1));
      a_re  = DW'($urandom);
      b_re  = DW'($urandom);
      tw_re = DW'($urandom);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_out();
    @(negedge clk);
    chk("T5_in_ready_after", 0, in_ready[0], 1);

    // Reset during MUL with ovf previously set
    run(2047, -2048, 100, -100, 128, 0);
    send(300, -200, 50, 60, 90, -90);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("T6_async_mul_en", 0, mul_en[0], 0);
    chk("T6_async_in_ready", 0, in_ready[0], 0);
    chk("T6_async_ovf", 0, ovf[0], 0);
    chk("T6_async_x_re", 0, $signed(x_re[0]), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run(0, 0, 10, 20, 0, -128);

    for (int i = 0; i < 8; i++)
      run(int'($urandom_range(4095)) - 2048, int'($urandom_range(4095)) - 2048,
          int'($urandom_range(4095)) - 2048, int'($urandom_range(4095)) - 2048,
          int'($urandom_range(256)) - 128, int'($urandom_range(256)) - 128);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", n_chk);
    $fatal(1, "watchdog timeout");
  end

endmodule
